fpga_mig_ui_bridge: RTL and testbench

FPGA_MIG_UI_BRIDGE -- requirements
Module: fpga_mig_ui_bridge

---
 rtl/fpga_mig_ui_bridge.sv | 123 ++++++++++++
 tb/tb_fpga_mig_ui_bridge.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_mig_ui_bridge.sv
// rtl/fpga_mig_ui_bridge.sv - single-outstanding 32-bit SoC request bridge onto a 128-bit MIG UI port
module fpga_mig_ui_bridge #(
    parameter int unsigned RD_TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init_calib_complete,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [27:0]  req_addr,
    input  logic [31:0]  req_wdata,
    input  logic [3:0]   req_be,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [31:0]  rsp_rdata,
    output logic         rsp_err,
    output logic [27:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic [15:0]  app_wdf_mask,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid,
    input  logic         app_rd_data_end
);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic [1:0]    lane;
    logic          cmd_done, dat_done;
    logic          accept, cmd_acc, dat_acc, tmo_hit;
    logic [15:0]   wmask;
    logic          unused_bits;

    assign accept      = req_ready & req_valid;
    assign cmd_acc     = app_en & app_rdy;
    assign dat_acc     = app_wdf_wren & app_wdf_rdy;
    assign tmo_hit     = (tmo_cnt == CW'(RD_TIMEOUT - 1));
    assign unused_bits = ^{app_rd_data_end, req_addr[1:0]};

    // Only the addressed lane is written; every other byte of the 128-bit beat stays masked.
    always_comb begin
        wmask = 16'hFFFF;
        wmask[{req_addr[3:2], 2'b00} +: 4] = ~req_be;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_we ? WR : RD_CMD;
            WR:      if ((cmd_done | cmd_acc) & (dat_done | dat_acc)) state_nxt = RESP;
            RD_CMD:  if (app_rdy) state_nxt = RD_WAIT;
            RD_WAIT: if (app_rd_data_valid | tmo_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state == IDLE) & init_calib_complete & ~reset;
        rsp_valid    = (state == RESP);
        app_en       = ((state == WR) & ~cmd_done) | (state == RD_CMD);
        app_wdf_wren = (state == WR) & ~dat_done;
        app_wdf_end  = (state == WR) & ~dat_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            app_addr     <= '0;
            app_cmd      <= '0;
            app_wdf_data <= '0;
            app_wdf_mask <= 16'hFFFF;
            lane         <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            cmd_done     <= 1'b0;
            dat_done     <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            if (accept) begin
                app_addr     <= {1'b0, req_addr[27:4], 3'b000};
                app_cmd      <= req_we ? 3'b000 : 3'b001;
                app_wdf_data <= {4{req_wdata}};
                app_wdf_mask <= wmask;
                lane         <= req_addr[3:2];
                rsp_rdata    <= '0;
                rsp_err      <= 1'b0;
                cmd_done     <= 1'b0;
                dat_done     <= 1'b0;
            end
            // Command and data channels may complete in either order.
            if (state == WR) begin
                if (cmd_acc) cmd_done <= 1'b1;
                if (dat_acc) dat_done <= 1'b1;
            end
            if (state == RD_CMD) tmo_cnt <= '0;
            if (state == RD_WAIT) begin
                if (app_rd_data_valid) begin
                    rsp_rdata <= app_rd_data[{lane, 5'b00000} +: 32];
                    rsp_err   <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fpga_mig_ui_bridge.sv
// tb/tb_fpga_mig_ui_bridge.sv - randomized self-checking bench for fpga_mig_ui_bridge
module tb_fpga_mig_ui_bridge;
    localparam int TMO = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         init_calib_complete = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [27:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_be = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy = 1'b0;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy = 1'b0;
    logic [127:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0;
    logic         app_rd_data_end = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fpga_mig_ui_bridge #(.RD_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_rsp(input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        #1;
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            app_rd_data_valid = 1'b1;
            app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("rsp_hold_valid", rsp_valid, 1'b1);
            check("rsp_hold_rdata", rsp_rdata, exp_rdata);
            check("rsp_hold_err", rsp_err, exp_err);
        end
        app_rd_data_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 1'b0);
        check("back_idle_ready", req_ready, 1'b1);
    endtask

    task automatic do_write(input logic [27:0] a, input logic [31:0] d, input logic [3:0] be,
                            input int cd, input int dd, input int hold);
        logic [15:0] m;
        logic [27:0] ea;
        logic        cdone, ddone;
        int          k;
        m = 16'hFFFF;
        for (int i = 0; i < 16; i++)
            if ((i / 4) == int'(a[3:2]) && be[i % 4]) m[i] = 1'b0;
        ea = 28'((a / 16) * 8);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        #1;
        check("wr_req_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0; req_addr = 28'($urandom); req_wdata = $urandom; req_be = 4'($urandom);
        cdone = 1'b0; ddone = 1'b0; k = 0;
        while (!(cdone && ddone)) begin
            app_rdy = (k >= cd);
            app_wdf_rdy = (k >= dd);
            #1;
            check("wr_app_en", app_en, !cdone);
            check("wr_wren", app_wdf_wren, !ddone);
            check("wr_wdf_end", app_wdf_end, !ddone);
            check("wr_no_rsp", rsp_valid, 1'b0);
            if (k == 0) begin
                check("wr_app_addr", app_addr, ea);
                check("wr_app_cmd", app_cmd, 3'b000);
                check("wr_wdf_data", app_wdf_data, {d, d, d, d});
                check("wr_wdf_mask", app_wdf_mask, m);
            end
            if (app_rdy) cdone = 1'b1;
            if (app_wdf_rdy) ddone = 1'b1;
            step();
            k++;
        end
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        finish_rsp(32'h0, 1'b0, hold);
    endtask

    task automatic do_read(input logic [27:0] a, input logic [127:0] rd, input int rdy_d,
                           input int vd, input int hold);
        logic [127:0] sh;
        logic [31:0]  exp;
        logic         timeout;
        int           endj;
        sh = rd >> (32 * int'(a[3:2]));
        exp = sh[31:0];
        timeout = (vd >= TMO);
        endj = timeout ? TMO - 1 : vd;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = $urandom; req_be = 4'($urandom);
        #1;
        check("rd_req_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0; req_addr = 28'($urandom);
        for (int k = 0; k <= rdy_d; k++) begin
            app_rdy = (k == rdy_d);
            app_rd_data_valid = 1'b1;
            app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("rd_app_en", app_en, 1'b1);
            check("rd_app_cmd", app_cmd, 3'b001);
            check("rd_app_addr", app_addr, 28'((a / 16) * 8));
            check("rd_cmd_no_rsp", rsp_valid, 1'b0);
            step();
        end
        app_rdy = 1'b0;
        for (int j = 0; j <= endj; j++) begin
            app_rd_data_valid = (j == vd);
            app_rd_data = (j == vd) ? rd : {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("rd_wait_no_en", app_en, 1'b0);
            check("rd_wait_no_rsp", rsp_valid, 1'b0);
            step();
        end
        app_rd_data_valid = 1'b0;
        finish_rsp(timeout ? 32'h0 : exp, timeout, hold);
    endtask

    initial begin
        repeat (2) step();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_app_en", app_en, 1'b0);
        check("rst_wren", app_wdf_wren, 1'b0);
        check("rst_wdf_end", app_wdf_end, 1'b0);
        check("rst_app_cmd", app_cmd, 3'b000);
        check("rst_app_addr", app_addr, 28'h0);
        check("rst_wdf_data", app_wdf_data, 128'h0);
        check("rst_wdf_mask", app_wdf_mask, 16'hFFFF);

        reset = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 28'h40;
        for (int c = 0; c < 4; c++) begin
            step();
            check("nocal_req_ready", req_ready, 1'b0);
            check("nocal_app_en", app_en, 1'b0);
            check("nocal_wren", app_wdf_wren, 1'b0);
        end
        init_calib_complete = 1'b1;
        do_read(28'h24, 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333, 0, 2, 0);

        do_write(28'h0000014, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
        do_write(28'h000000C, 32'h12345678, 4'b0101, 0, 5, 1);
        do_write(28'h0000100, 32'hCAFEF00D, 4'b1000, 3, 0, 0);
        do_read(28'h0000008, 128'h44444444_33333333_22222222_11111111, 0, 5, 0);
        do_read(28'h0000030, 128'h0, 1, 1000, 2);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(28'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4),
                         $urandom_range(0, 4), $urandom_range(0, 2));
            else
                do_read(28'($urandom), {$urandom, $urandom, $urandom, $urandom},
                        $urandom_range(0, 3), $urandom_range(1, 20), $urandom_range(0, 2));
        end

        // Abandon a read sitting in RD_WAIT, then feed it stale data.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h88;
        step();
        req_valid = 1'b0; app_rdy = 1'b1;
        step();
        app_rdy = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        app_rd_data_valid = 1'b1;
        app_rd_data = {4{32'h5A5A5A5A}};
        step();
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_app_en", app_en, 1'b0);
        check("mid_rst_app_addr", app_addr, 28'h0);
        check("mid_rst_wdf_mask", app_wdf_mask, 16'hFFFF);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("post_rst_rsp_valid", rsp_valid, 1'b0);
            check("post_rst_req_ready", req_ready, 1'b1);
            check("post_rst_app_en", app_en, 1'b0);
            check("post_rst_rdata", rsp_rdata, 32'h0);
        end
        app_rd_data_valid = 1'b0;
        do_write(28'h0FFFFFC, 32'h0BADF00D, 4'b0011, 1, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
